// File: rtl/fft_request_arbiter_if.sv
// Requester / FFT-engine bus of fft_request_arbiter.
// The master modport is the arbiter's view. The slave modport is the clients' and engine's view.
interface fft_request_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*4*DATA_W-1:0] req_row_data;
  logic [1:0]                  row_idx;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          ack;
  logic [NUM_REQ-1:0]          err;
  logic                        busy;
  logic                        fft_start;
  logic                        fft_row_valid;
  logic [4*DATA_W-1:0]         fft_row_data;
  logic                        fft_done;

  modport master (
    input  req, req_row_data, fft_done,
    output row_idx, grant, ack, err, busy, fft_start, fft_row_valid, fft_row_data
  );

  modport slave (
    output req, req_row_data, fft_done,
    input  row_idx, grant, ack, err, busy, fft_start, fft_row_valid, fft_row_data
  );
endinterface

// File: rtl/fft_request_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4x4 2D FFT engine between NUM_REQ requesters.
// Define FFT_ARB_TIMEOUT_EN to abort a stalled WAIT with err after TIMEOUT_CYC cycles.
module fft_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fft_request_arbiter_if.master bus
);
  // state   | meaning
  // IDLE    | no owner, arbitrate among pending requests
  // LOAD    | stream rows 0..3 of the owner into the engine
  // WAIT    | wait for fft_done
  // RELEASE | ack/err pulse visible, grant cleared on exit
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RELEASE} state_t;

  localparam int ROW_W = 4 * DATA_W;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant_q, grant_d, ack_q, ack_d, err_q, err_d;
  logic               busy_q, busy_d, start_q, start_d, row_valid_q, row_valid_d;
  logic [1:0]         row_idx_q, row_idx_d;
`ifdef FFT_ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  // first pending requester at or after rr_ptr, with wrap
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && bus.req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    ack_d       = '0;
    err_d       = '0;
    busy_d      = busy_q;
    start_d     = 1'b0;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
`ifdef FFT_ARB_TIMEOUT_EN
    timer_d     = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          grant_d     = NUM_REQ'(1) << pick_idx;
          busy_d      = 1'b1;
          start_d     = 1'b1;
          row_valid_d = 1'b1;
          row_idx_d   = 2'd0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (row_idx_q == 2'd3) begin
          row_valid_d = 1'b0;
          row_idx_d   = 2'd0;
`ifdef FFT_ARB_TIMEOUT_EN
          timer_d     = TIMER_W'(TIMEOUT_CYC);
`endif
          state_d     = WAIT;
        end else begin
          row_idx_d = row_idx_q + 2'd1;
        end
      end
      WAIT: begin
        // fft_done wins over a timeout reached in the same cycle
        if (bus.fft_done) begin
          ack_d   = grant_q;
          state_d = RELEASE;
        end
`ifdef FFT_ARB_TIMEOUT_EN
        else if (timer_q == '0) begin
          err_d   = grant_q;
          state_d = RELEASE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
`endif
      end
      RELEASE: begin
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= 2'd0;
`ifdef FFT_ARB_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
`ifdef FFT_ARB_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  // row mux follows the registered grant, so it is zero whenever idle
  always_comb begin
    bus.fft_row_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) bus.fft_row_data = bus.fft_row_data | bus.req_row_data[k*ROW_W +: ROW_W];
    end
  end

  assign bus.grant         = grant_q;
  assign bus.ack           = ack_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;
  assign bus.fft_start     = start_q;
  assign bus.fft_row_valid = row_valid_q;
  assign bus.row_idx       = row_idx_q;
endmodule
